// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/load-store requesters, the shared memory port and the arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  logic [DW-1:0] rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_gnt, i_done, d_gnt, d_done, m_req, m_we, m_addr, m_wdata, rdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_gnt, i_done, d_gnt, d_done, m_req, m_we, m_addr, m_wdata, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and load/store (D).
// Tracks each transaction to the memory acknowledge and returns a one-cycle done pulse to its owner.
//
// state | meaning
// IDLE  | no transaction; arbitrate between i_req and d_req
// BUSY  | owner's access presented on the memory port, waiting for m_ack
// DONE  | one-cycle done pulse to the owner, rdata valid; no arbitration
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          sel;
  logic          last;
  logic          m_req_q;
  logic          i_gnt_q;
  logic          d_gnt_q;
  logic          i_done_q;
  logic          d_done_q;
  logic [DW-1:0] rdata_q;

  logic          pick_d;
  logic          owner_req;
  logic          ack_ok;
  logic [AW-1:0] addr_mux;

  // On contention the side not served last wins; a lone requester always wins.
  assign pick_d    = bus.d_req & (~bus.i_req | ~last);
  assign owner_req = sel ? bus.d_req : bus.i_req;
  // An ack arriving while the owner has dropped its request is not trusted.
  assign ack_ok    = bus.m_ack & owner_req;
  assign addr_mux  = sel ? bus.d_addr : bus.i_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      m_req_q  <= 1'b0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          if (bus.i_req | bus.d_req) begin
            sel     <= pick_d;
            i_gnt_q <= ~pick_d;
            d_gnt_q <= pick_d;
            m_req_q <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (ack_ok) begin
            if (!(sel & bus.d_we)) begin
              rdata_q <= bus.m_rdata;
            end
            last     <= sel;
            m_req_q  <= 1'b0;
            i_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
            i_done_q <= ~sel;
            d_done_q <= sel;
            state    <= DONE;
          end
        end
        DONE: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          m_req_q  <= 1'b0;
          i_gnt_q  <= 1'b0;
          d_gnt_q  <= 1'b0;
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_req_q & sel & bus.d_we;
  assign bus.m_addr  = addr_mux;
  assign bus.m_wdata = bus.d_wdata;
  assign bus.i_gnt   = i_gnt_q;
  assign bus.d_gnt   = d_gnt_q;
  assign bus.i_done  = i_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.rdata   = rdata_q;

endmodule
